// File: rtl/universal_dreg.sv
// universal_dreg: a WIDTH-bit register that can hold, load, shift, rotate,
// clear or set, one operation per clock.
// Outputs:
//   - q, q_bar and the changed flag are registered.
//   - The serial-out taps are taken straight from registered q.
// Optional feature, macro UNIVERSAL_DREG_PARITY_EN: adds a registered
// even-parity output, par, that stays aligned with q.
module universal_dreg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             changed
`ifdef UNIVERSAL_DREG_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_SET  = 3'b111;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_bar_q;
  logic             changed_q;

`ifdef UNIVERSAL_DREG_PARITY_EN
  logic par_q;

  // XOR reduction of a register value: 1 when an odd number of bits are set.
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    parity_of = ^v;
  endfunction
`endif

  // Next-state selection: the mode decoder is only consulted when en is high.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = d;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_lsb};
        MODE_SHR:  q_d = {sin_msb, q_q[WIDTH-1:1]};
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_CLR:  q_d = {WIDTH{1'b0}};
        MODE_SET:  q_d = {WIDTH{1'b1}};
        default:   q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  // State register.
  // q_bar is registered from ~q_d, so it always matches ~q without an inverter
  // after the flop. changed compares the new value against the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RESET_VAL;
      q_bar_q   <= ~RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_bar_q   <= ~q_d;
      changed_q <= (q_d != q_q);
    end
  end

`ifdef UNIVERSAL_DREG_PARITY_EN
  // Parity register, computed from the next state so that it updates on the
  // same edge as q.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= parity_of(RESET_VAL);
    end else begin
      par_q <= parity_of(q_d);
    end
  end

  assign par = par_q;
`endif

  assign q        = q_q;
  assign q_bar    = q_bar_q;
  assign changed  = changed_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];

endmodule

// File: tb/tb_universal_dreg.sv
// Directed self-checking bench for universal_dreg (WIDTH=8, RESET_VAL=0).
// The bench keeps its own model of the register. Expected results are pushed
// to a queue as stimulus is driven, then popped and compared after the edge.
module tb_universal_dreg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_lsb;
  logic       sin_msb;
  logic [7:0] q;
  logic [7:0] q_bar;
  logic       sout_msb;
  logic       sout_lsb;
  logic       changed;
`ifdef UNIVERSAL_DREG_PARITY_EN
  logic       par;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic       ch;
    logic       par;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_q;
  int         n_cmp = 0;
  int         n_err = 0;

  universal_dreg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_lsb  (sin_lsb),
    .sin_msb  (sin_msb),
    .q        (q),
    .q_bar    (q_bar),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .changed  (changed)
`ifdef UNIVERSAL_DREG_PARITY_EN
    ,
    .par      (par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then check it after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dv, input logic sl, input logic sm);
    logic [7:0] nq;
    exp_t       ex;
    exp_t       got;
    @(negedge clk);
    rst = r; en = e; mode = m; d = dv; sin_lsb = sl; sin_msb = sm;
    if (r) begin
      nq = 8'h00;
    end else if (e) begin
      case (m)
        3'b000:  nq = model_q;
        3'b001:  nq = dv;
        3'b010:  nq = {model_q[6:0], sl};
        3'b011:  nq = {sm, model_q[7:1]};
        3'b100:  nq = {model_q[6:0], model_q[7]};
        3'b101:  nq = {model_q[0], model_q[7:1]};
        3'b110:  nq = 8'h00;
        default: nq = 8'hFF;
      endcase
    end else begin
      nq = model_q;
    end
    ex.q   = nq;
    ex.ch  = r ? 1'b0 : (nq != model_q);
    ex.par = ^nq;
    sb_q.push_back(ex);
    model_q = nq;
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".q"}, q, got.q);
    chk({tag, ".q_bar"}, q_bar, ~got.q);
    chk({tag, ".changed"}, {7'd0, changed}, {7'd0, got.ch});
    chk({tag, ".sout_msb"}, {7'd0, sout_msb}, {7'd0, got.q[7]});
    chk({tag, ".sout_lsb"}, {7'd0, sout_lsb}, {7'd0, got.q[0]});
`ifdef UNIVERSAL_DREG_PARITY_EN
    chk({tag, ".par"}, {7'd0, par}, {7'd0, got.par});
`endif
  endtask

  initial begin
    model_q = 8'h00;
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin_lsb = 1'b0; sin_msb = 1'b0;

    // Reset wins over a pending load of FF.
    step("reset", 1'b1, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);

    // Load A5, then hold for three edges with a set request.
    step("load_a5", 1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_a5", 1'b0, 1'b0, 3'b111, 8'h3C, 1'b1, 1'b1);

    // Rotate left, then rotate right, starting from 81.
    step("load_81", 1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
    step("rol_81", 1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    step("ror_03", 1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);

    // Fill with ones by shifting left, then drain with zeros by shifting right.
    step("clr", 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("shl_fill", 1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step("shr_drain", 1'b0, 1'b1, 3'b011, 8'hFF, 1'b1, 1'b0);

    // Rotating a uniform value must not change it.
    step("set", 1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    step("rol_ff", 1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    step("clr_ff", 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    step("ror_00", 1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);

    // Loading the current value must leave changed low.
    step("load_same", 1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    step("load_6c", 1'b0, 1'b1, 3'b001, 8'h6C, 1'b0, 1'b0);
    step("load_same2", 1'b0, 1'b1, 3'b001, 8'h6C, 1'b0, 1'b0);

    // Reset in the middle of a shift sequence discards the sequence.
    step("load_5a", 1'b0, 1'b1, 3'b001, 8'h5A, 1'b0, 1'b0);
    step("shl_5a", 1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    step("rst_mid", 1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    step("shl_post", 1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);

    // Parity tracks q.
    step("load_07", 1'b0, 1'b1, 3'b001, 8'h07, 1'b0, 1'b0);
    step("load_03", 1'b0, 1'b1, 3'b001, 8'h03, 1'b0, 1'b0);

    // en=0 holds q whatever mode, d and the serial inputs are doing.
    for (int i = 0; i < 6; i++)
      step("hold_rand", 1'b0, 1'b0, 3'($urandom_range(7, 0)), 8'($urandom),
           1'($urandom), 1'($urandom));

    // Mixed operations with random data.
    for (int i = 0; i < 12; i++)
      step("rand_op", 1'b0, 1'b1, 3'($urandom_range(7, 0)), 8'($urandom),
           1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
